// File: rtl/u_img_pkg.sv
// Shared image-path constants, pixel type and index-width helper.
package u_img_pkg;

    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int DW_DEF         = 8;

    typedef logic [DW_DEF-1:0] pix_t;

    // Bits needed to index n entries (never less than 1).
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/u_line_ram.sv
// Simple dual-port line RAM: one write port, one synchronous read port.
// A read and write to the same address in one cycle returns the old data.
module u_line_ram #(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int DEPTH = 640
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:DEPTH-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register holds its value while re_i is low, so taps stay put in gaps.
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/u_line_tap_gen.sv
// Line-buffer tap generator feeding a 3x3 window: three vertically aligned taps per pixel.
// Optional top-border replication: define U_LINE_TAP_BORDER_REPLICATE_EN.
module u_line_tap_gen
    import u_img_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int DW         = DW_DEF,
    parameter int AW         = idx_width(IMG_WIDTH),
    parameter int RW         = idx_width(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [DW-1:0] data_line_0,
    output logic [DW-1:0] data_line_1,
    output logic [DW-1:0] data_line_2,
    output logic          tap_ce,
    output logic          tap_valid,
    output logic [AW-1:0] col_out,
    output logic [RW-1:0] row_out,
    output logic          eof
);

    logic [AW-1:0] col_q, col_d, col_use;
    logic [RW-1:0] row_q, row_d, row_use;
    logic          wr_sel_q, wr_sel_d;
    logic          last_col, last_row;

    logic [DW-1:0] pix_q;
    logic [AW-1:0] col_out_q;
    logic [RW-1:0] row_out_q;
    logic          sel_q, tap_ce_q, tap_valid_q, eof_q;

    logic [DW-1:0] rd_a, rd_b, row1_rd, row2_rd;
    logic [DW-1:0] line0, line1;

    // sof overrides the counters for the pixel presented alongside it.
    always_comb begin
        col_use  = sof ? '0 : col_q;
        row_use  = sof ? '0 : row_q;
        last_col = (col_use == AW'(IMG_WIDTH - 1));
        last_row = (row_use == RW'(IMG_HEIGHT - 1));
        col_d    = col_use;
        row_d    = row_use;
        wr_sel_d = wr_sel_q;
        if (pix_valid) begin
            if (last_col) begin
                col_d    = '0;
                wr_sel_d = ~wr_sel_q;
                row_d    = last_row ? '0 : row_use + RW'(1);
            end else begin
                col_d = col_use + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q    <= '0;
            row_q    <= '0;
            wr_sel_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            wr_sel_q <= wr_sel_d;
        end
    end

    // wr_sel_q=0: ram_a is the row-2 RAM (written), ram_b holds row-1.
    u_line_ram #(.DW(DW), .AW(AW), .DEPTH(IMG_WIDTH)) ram_a (
        .clk     (clk),
        .we_i    (pix_valid & ~wr_sel_q),
        .waddr_i (col_use),
        .wdata_i (pix_in),
        .re_i    (pix_valid),
        .raddr_i (col_use),
        .rdata_o (rd_a)
    );

    u_line_ram #(.DW(DW), .AW(AW), .DEPTH(IMG_WIDTH)) ram_b (
        .clk     (clk),
        .we_i    (pix_valid & wr_sel_q),
        .waddr_i (col_use),
        .wdata_i (pix_in),
        .re_i    (pix_valid),
        .raddr_i (col_use),
        .rdata_o (rd_b)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_q       <= '0;
            col_out_q   <= '0;
            row_out_q   <= '0;
            sel_q       <= 1'b0;
            tap_ce_q    <= 1'b0;
            tap_valid_q <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            tap_ce_q <= pix_valid;
            eof_q    <= pix_valid & last_col & last_row;
            if (pix_valid) begin
                pix_q     <= pix_in;
                col_out_q <= col_use;
                row_out_q <= row_use;
                sel_q     <= wr_sel_q;
`ifdef U_LINE_TAP_BORDER_REPLICATE_EN
                tap_valid_q <= 1'b1;
`else
                tap_valid_q <= (row_use >= RW'(2));
`endif
            end
        end
    end

    // Rows not yet buffered in this frame are masked so stale RAM never leaks out.
    always_comb begin
        row1_rd = sel_q ? rd_a : rd_b;
        row2_rd = sel_q ? rd_b : rd_a;
        line0   = (row_out_q >= RW'(2)) ? row2_rd : '0;
        line1   = (row_out_q != '0) ? row1_rd : '0;
`ifdef U_LINE_TAP_BORDER_REPLICATE_EN
        if (row_out_q == '0) begin
            line0 = pix_q;
            line1 = pix_q;
        end else if (row_out_q == RW'(1)) begin
            line0 = row1_rd;
        end
`endif
    end

    assign data_line_0 = line0;
    assign data_line_1 = line1;
    assign data_line_2 = pix_q;
    assign tap_ce      = tap_ce_q;
    assign tap_valid   = tap_valid_q;
    assign col_out     = col_out_q;
    assign row_out     = row_out_q;
    assign eof         = eof_q;

endmodule
